// File: rtl/ysyx_22050854_reg_read_if.sv
// Issue-side and execute-side handshake bundle
// for the operand-read stage.
interface ysyx_22050854_reg_read_if #(
    parameter int XLEN = 64,
    parameter int PCW  = 64
);
    logic            in_valid;
    logic            in_ready;
    logic [4:0]      in_rs1;
    logic [4:0]      in_rs2;
    logic [4:0]      in_rd;
    logic            in_rd_wen;
    logic [PCW-1:0]  in_pc;

    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_src1;
    logic [XLEN-1:0] out_src2;
    logic [4:0]      out_rd;
    logic            out_rd_wen;
    logic [PCW-1:0]  out_pc;

    modport master (
        output in_valid, in_rs1, in_rs2,
        output in_rd, in_rd_wen, in_pc,
        input  in_ready,
        input  out_valid, out_src1, out_src2,
        input  out_rd, out_rd_wen, out_pc,
        output out_ready
    );

    modport slave (
        input  in_valid, in_rs1, in_rs2,
        input  in_rd, in_rd_wen, in_pc,
        output in_ready,
        output out_valid, out_src1, out_src2,
        output out_rd, out_rd_wen, out_pc,
        input  out_ready
    );
endinterface

// File: rtl/ysyx_22050854_reg_read.sv
// Operand-read stage: regfile read, write-back bypass,
// pending-write scoreboard and one-entry output register.
module ysyx_22050854_reg_read #(
    parameter int XLEN = 64,
    parameter int PCW  = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    ysyx_22050854_reg_read_if.slave io,
    output logic [4:0]           raddra,
    output logic [4:0]           raddrb,
    input  logic [XLEN-1:0]      rdata1,
    input  logic [XLEN-1:0]      rdata2,
    input  logic                 wb_en,
    input  logic [4:0]           wb_rd,
    input  logic [XLEN-1:0]      wb_data,
    input  logic                 flush
);
    logic [31:0]     sb;
    logic [31:0]     sb_nxt;
    logic            ov;
    logic [XLEN-1:0] os1;
    logic [XLEN-1:0] os2;
    logic [4:0]      ord;
    logic            owen;
    logic [PCW-1:0]  opc;

    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic            byp1;
    logic            byp2;
    logic            bypd;
    logic [XLEN-1:0] src1;
    logic [XLEN-1:0] src2;
    logic            raw1;
    logic            raw2;
    logic            waw;
    logic            ready;
    logic            fire;

    assign rs1    = io.in_rs1;
    assign rs2    = io.in_rs2;
    assign rd     = io.in_rd;
    assign raddra = rs1;
    assign raddrb = rs2;

    // write-back this cycle is not yet visible in the regfile
    assign byp1 = wb_en && (wb_rd == rs1);
    assign byp2 = wb_en && (wb_rd == rs2);
    assign bypd = wb_en && (wb_rd == rd);

    assign src1 = (rs1 == 5'd0) ? '0
                : byp1 ? wb_data : rdata1;
    assign src2 = (rs2 == 5'd0) ? '0
                : byp2 ? wb_data : rdata2;

    assign raw1 = (rs1 != 5'd0) && sb[rs1] && !byp1;
    assign raw2 = (rs2 != 5'd0) && sb[rs2] && !byp2;
    assign waw  = io.in_rd_wen && (rd != 5'd0)
               && sb[rd] && !bypd;

    assign ready = !flush && !raw1 && !raw2 && !waw
                && (!ov || io.out_ready);
    assign fire  = io.in_valid && ready;

    assign io.in_ready   = ready;
    assign io.out_valid  = ov;
    assign io.out_src1   = os1;
    assign io.out_src2   = os2;
    assign io.out_rd     = ord;
    assign io.out_rd_wen = owen;
    assign io.out_pc     = opc;

    // clears first, then the issue set, so set wins on a tie
    always_comb begin
        sb_nxt = sb;
        if (wb_en && wb_rd != 5'd0)
            sb_nxt[wb_rd] = 1'b0;
        if (flush && ov && owen)
            sb_nxt[ord] = 1'b0;
        if (fire && io.in_rd_wen && rd != 5'd0)
            sb_nxt[rd] = 1'b1;
        sb_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sb <= '0;
        end else begin
            sb <= sb_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ov   <= 1'b0;
            os1  <= '0;
            os2  <= '0;
            ord  <= 5'd0;
            owen <= 1'b0;
            opc  <= '0;
        end else if (flush) begin
            ov <= 1'b0;
        end else if (fire) begin
            ov   <= 1'b1;
            os1  <= src1;
            os2  <= src2;
            ord  <= rd;
            owen <= io.in_rd_wen;
            opc  <= io.in_pc;
        end else if (io.out_ready) begin
            ov <= 1'b0;
        end
    end
endmodule

// File: tb/tb_ysyx_22050854_reg_read.sv
// Scoreboard bench for the operand-read stage:
// directed issue vectors, monitor checks each transfer.
module tb_ysyx_22050854_reg_read;
    logic        clk;
    logic        rst_n;
    logic [4:0]  raddra;
    logic [4:0]  raddrb;
    logic [63:0] rdata1;
    logic [63:0] rdata2;
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic [63:0] wb_data;
    logic        flush;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [63:0] s1;
        logic [63:0] s2;
        logic [4:0]  rd;
        logic        wen;
        logic [63:0] pc;
    } exp_t;

    exp_t q[$];

    ysyx_22050854_reg_read_if bus ();

    ysyx_22050854_reg_read dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .io      (bus),
        .raddra  (raddra),
        .raddrb  (raddrb),
        .rdata1  (rdata1),
        .rdata2  (rdata2),
        .wb_en   (wb_en),
        .wb_rd   (wb_rd),
        .wb_data (wb_data),
        .flush   (flush)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm,
                       input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h",
                     nm, act, exp);
        end
    endtask

    function automatic exp_t mk(
        input logic [63:0] s1, input logic [63:0] s2,
        input logic [4:0] rd, input logic wen,
        input logic [63:0] pc);
        exp_t e;
        e.s1 = s1; e.s2 = s2; e.rd = rd;
        e.wen = wen; e.pc = pc;
        return e;
    endfunction

    // transfer happens at the next edge when valid && ready
    always @(negedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready) begin
            if (q.size() == 0) begin
                chk("unexpected_out", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("out_src1", bus.out_src1, e.s1);
                chk("out_src2", bus.out_src2, e.s2);
                chk("out_rd", {59'd0, bus.out_rd},
                    {59'd0, e.rd});
                chk("out_rd_wen", {63'd0, bus.out_rd_wen},
                    {63'd0, e.wen});
                chk("out_pc", bus.out_pc, e.pc);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [4:0] r1,
                         input logic [4:0] r2,
                         input logic [4:0] rd,
                         input logic wen,
                         input logic [63:0] pc,
                         input logic [63:0] d1,
                         input logic [63:0] d2);
        bus.in_valid  = 1'b1;
        bus.in_rs1    = r1;
        bus.in_rs2    = r2;
        bus.in_rd     = rd;
        bus.in_rd_wen = wen;
        bus.in_pc     = pc;
        rdata1        = d1;
        rdata2        = d2;
    endtask

    // check ready, record expectation if it fires, advance a cycle
    task automatic try(input string nm,
                       input logic exp_rdy,
                       input exp_t e);
        #2;
        chk(nm, {63'd0, bus.in_ready}, {63'd0, exp_rdy});
        if (exp_rdy) q.push_back(e);
        step();
    endtask

    task automatic idle();
        bus.in_valid = 1'b0;
        step();
    endtask

    exp_t nx;

    initial begin
        nx = mk(0, 0, 0, 0, 0);
        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_rs1 = 0; bus.in_rs2 = 0; bus.in_rd = 0;
        bus.in_rd_wen = 0; bus.in_pc = 0;
        bus.out_ready = 1'b1;
        rdata1 = 0; rdata2 = 0;
        wb_en = 0; wb_rd = 0; wb_data = 0; flush = 0;
        step();
        step();
        chk("rst_out_valid", {63'd0, bus.out_valid}, 0);
        chk("rst_out_src1", bus.out_src1, 0);
        chk("rst_out_src2", bus.out_src2, 0);
        chk("rst_out_pc", bus.out_pc, 0);
        chk("rst_out_rd", {59'd0, bus.out_rd}, 0);
        chk("rst_out_wen", {63'd0, bus.out_rd_wen}, 0);
        rst_n = 1'b1;
        step();

        // basic issue and x0 handling
        drive(3, 0, 1, 0, 64'h100, 64'h11, 64'h22);
        #1;
        chk("raddra", {59'd0, raddra}, 64'd3);
        chk("raddrb", {59'd0, raddrb}, 64'd0);
        try("rdy_basic", 1, mk(64'h11, 0, 1, 0, 64'h100));
        chk("valid_after_issue",
            {63'd0, bus.out_valid}, 64'd1);
        drive(0, 3, 2, 0, 64'h104, 64'hFF, 64'h33);
        try("rdy_x0", 1, mk(0, 64'h33, 2, 0, 64'h104));
        idle();

        // RAW stall resolved by write-back bypass
        drive(1, 2, 5, 1, 64'h200, 64'h1, 64'h2);
        try("rdy_A5", 1, mk(1, 2, 5, 1, 64'h200));
        drive(5, 0, 6, 0, 64'h204, 64'hDEAD, 0);
        try("raw_stall0", 0, nx);
        try("raw_stall1", 0, nx);
        wb_en = 1; wb_rd = 5; wb_data = 64'hABCD;
        try("raw_wb", 1, mk(64'hABCD, 0, 6, 0, 64'h204));
        wb_en = 0;
        drive(5, 5, 0, 1, 64'h208, 64'hABCD, 64'hABCD);
        try("rdy_x5_clear", 1,
            mk(64'hABCD, 64'hABCD, 0, 1, 64'h208));

        // WAW stall; set wins over same-cycle clear
        drive(0, 0, 7, 1, 64'h300, 64'h5, 64'h6);
        try("rdy_A7", 1, mk(0, 0, 7, 1, 64'h300));
        drive(0, 0, 7, 1, 64'h304, 0, 0);
        try("waw_stall0", 0, nx);
        try("waw_stall1", 0, nx);
        wb_en = 1; wb_rd = 7; wb_data = 64'h77;
        try("waw_wb", 1, mk(0, 0, 7, 1, 64'h304));
        wb_en = 0;
        drive(7, 0, 11, 0, 64'h308, 64'h70, 0);
        try("set_wins_stall", 0, nx);
        chk("sb7_set", {63'd0, dut.sb[7]}, 64'd1);
        wb_en = 1; wb_rd = 7; wb_data = 64'h99;
        try("x7_wb", 1, mk(64'h99, 0, 11, 0, 64'h308));
        wb_en = 0;
        idle();

        // backpressure: outputs hold, then one transfer
        bus.out_ready = 1'b0;
        drive(1, 2, 8, 0, 64'h400, 64'hA, 64'hB);
        try("rdy_F", 1, mk(64'hA, 64'hB, 8, 0, 64'h400));
        drive(3, 4, 0, 0, 64'h404, 64'hC, 64'hD);
        for (int i = 0; i < 3; i++) begin
            chk("hold_valid", {63'd0, bus.out_valid}, 1);
            chk("hold_src1", bus.out_src1, 64'hA);
            chk("hold_pc", bus.out_pc, 64'h400);
            try("bp_stall", 0, nx);
        end
        bus.out_ready = 1'b1;
        try("bp_release", 1, mk(64'hC, 64'hD, 0, 0, 64'h404));
        idle();

        // flush kills a held rd=9 entry and its sb bit
        bus.out_ready = 1'b0;
        drive(0, 0, 9, 1, 64'h500, 0, 0);
        try("rdy_H9", 1, nx);
        void'(q.pop_back());
        chk("held_rd9", {59'd0, bus.out_rd}, 64'd9);
        flush = 1;
        drive(9, 0, 10, 0, 64'h504, 64'h99, 0);
        try("flush_blocks", 0, nx);
        flush = 0;
        chk("flush_valid", {63'd0, bus.out_valid}, 0);
        bus.out_ready = 1'b1;
        try("x9_after_flush", 1, mk(64'h99, 0, 10, 0, 64'h504));
        idle();
        flush = 1;
        drive(0, 0, 0, 0, 64'h508, 0, 0);
        try("flush_idle", 0, nx);
        flush = 0;
        try("after_flush_idle", 1, mk(0, 0, 0, 0, 64'h508));
        idle();

        // async reset in the middle of a stall
        drive(0, 0, 4, 1, 64'h600, 0, 0);
        try("rdy_K4", 1, nx);
        void'(q.pop_back());
        bus.out_ready = 1'b0;
        drive(4, 0, 12, 0, 64'h604, 64'h44, 0);
        try("stall_x4", 0, nx);
        chk("pre_rst_valid", {63'd0, bus.out_valid}, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", {63'd0, bus.out_valid}, 0);
        chk("arst_rd", {59'd0, bus.out_rd}, 0);
        chk("arst_pc", bus.out_pc, 0);
        chk("arst_sb4", {63'd0, dut.sb[4]}, 0);
        bus.in_valid = 1'b0;
        q.delete();
        step();
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        drive(4, 0, 12, 0, 64'h604, 64'h44, 0);
        try("x4_after_rst", 1, mk(64'h44, 0, 12, 0, 64'h604));
        idle();
        idle();
        chk("queue_empty", q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ysyx_22050854_reg_read.md
Name: ysyx_22050854_reg_read

Overview:
- Operand-read stage; the read-side counterpart of the write-back path into `ysyx_22050854_RegisterFile`.
- Accepts decoded instructions over a valid/ready handshake and drives the register file read addresses (`raddra`/`raddrb`).
- Forwards same-cycle write-back data and tracks pending writes in a 32-entry scoreboard so hazards stall issue.
- Registers the operands into a one-entry output stage toward execute.

Parameters:
- XLEN, 64, datapath width of operands and write-back data.
- PCW, 64, width of the pass-through PC.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  decoded instruction available
- in_ready  out  1  stage accepts instruction this cycle
- in_rs1  in  5  source register 1 index
- in_rs2  in  5  source register 2 index
- in_rd  in  5  destination register index
- in_rd_wen  in  1  instruction writes in_rd
- in_pc  in  PCW  instruction PC
- raddra  out  5  register file read address A (= in_rs1)
- raddrb  out  5  register file read address B (= in_rs2)
- rdata1  in  XLEN  register file data for raddra, combinational same cycle
- rdata2  in  XLEN  register file data for raddrb, combinational same cycle
- wb_en  in  1  write-back writes register this cycle (same as RegWr)
- wb_rd  in  5  write-back destination
- wb_data  in  XLEN  write-back data
- flush  in  1  kill the entry held in the output register
- out_valid  out  1  operands valid toward execute
- out_ready  in  1  execute accepts
- out_src1  out  XLEN  operand 1
- out_src2  out  XLEN  operand 2
- out_rd  out  5  destination
- out_rd_wen  out  1  destination write enable
- out_pc  out  PCW  PC

Behaviour:
Reset:
- `out_valid`=0; `out_src1`/`out_src2`/`out_pc`=0; `out_rd`=0; `out_rd_wen`=0; scoreboard `sb[31:0]`=0.
- Reset is asynchronous and may assert mid-stall; all state clears immediately.

Addresses:
- `raddra`=`in_rs1` and `raddrb`=`in_rs2` combinationally at all times, regardless of `in_valid`.

Operand select, per source:
- rs==0 → 0.
- else `wb_en` && `wb_rd`==rs → `wb_data` (bypass; the register file write is not yet visible).
- else `rdata`.

Hazards and ready:
- `wb_clr(r)` = `wb_en` && `wb_rd`==r && r!=0.
- RAW: rs!=0 && `sb[rs]` && !`wb_clr(rs)`, applied to `in_rs1` and `in_rs2`.
- WAW: `in_rd_wen` && `in_rd`!=0 && `sb[in_rd]` && !`wb_clr(in_rd)`.
- `in_ready` = !flush && !RAW && !WAW && (!`out_valid` || `out_ready`). It is combinational and independent of `in_valid`.

Issue:
- fire = `in_valid` && `in_ready`. On fire, the output registers load the selected operands, `in_rd`, `in_rd_wen` and `in_pc`, and `out_valid`←1.
- If there is no fire and `out_ready`, `out_valid`←0.
- While `out_valid` && !`out_ready`, all out_* hold stable.
- Issue latency: 1 cycle. Back-to-back issue gives 1 instruction per cycle.

Scoreboard, per cycle, applied in order:
1. Clear `sb[wb_rd]` if `wb_clr`.
2. Set `sb[in_rd]` on fire if `in_rd_wen` && `in_rd`!=0.
- Set wins when both hit the same index in one cycle.
- `sb[0]` is always 0.
- `wb_rd`=0 or a write-back to a non-pending register is harmless: no state change beyond the clear.

Flush:
- Highest priority. Forces `in_ready`=0 (no fire) and `out_valid`←0.
- If the killed entry was valid with `out_rd_wen` && `out_rd`!=0, that `sb` bit is cleared.
- Instructions already past this stage keep their bits and clear them normally at write-back.
- Flush with `out_valid`=0 only blocks issue for that cycle.

Test Plan:
- Reset, then issue rs1=3, rs2=0, `rdata1`=0x11 → next cycle `out_valid`=1, `out_src1`=0x11, `out_src2`=0; rs1=0 with `rdata1`=0xFF also yields 0.
- Issue A (rd=5, wen), then B (rs1=5) → B stalls (`in_ready`=0) until `wb_en`, `wb_rd`=5, `wb_data`=0xABCD; in that same cycle B fires with `out_src1`=0xABCD and `sb[5]` clears.
- Issue A (rd=7), then C (rd=7, wen) with no write-back → WAW stall; write-back to 7 in the same cycle as C fires → `sb[7]` remains 1 (set wins).
- `out_ready`=0 for 3 cycles with `out_valid`=1 → out_* stable, `in_ready`=0; `out_ready`=1 → one transfer, next instruction loads the same cycle.
- Output holds rd=9 wen; assert flush → `out_valid`=0 next cycle, `sb[9]`=0, and a following read of x9 issues without a stall.
- Assert `rst_n`=0 mid-stall with `sb[4]`=1 → `out_valid`, `sb` cleared asynchronously; after release, a read of x4 issues immediately.
